// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Symbol codes shared by the HDB3 substitution stage and the downstream
// polarity-assignment stage. The polarity stage alternates mark/B pulses
// and V pulses from these codes.
package hdb3_pkg;

    typedef logic [1:0] code_t;

    localparam code_t CODE_ZERO = 2'b00;
    localparam code_t CODE_MARK = 2'b01;
    localparam code_t CODE_B    = 2'b10;
    localparam code_t CODE_V    = 2'b11;

endpackage

// File: rtl/hdb3_vb_insert_if.sv
// hdb3_vb_insert_if
// Bit-stream in / symbol-code out bundle for the HDB3 substitution stage.
//   en        : bit enable, data_in sampled only when high
//   data_in   : NRZ data bit
//   code_out  : 2-bit symbol code (zero / mark / B / V)
//   out_valid : code_out carries a real symbol this cycle
// master = bit source (drives en/data_in), slave = substitution stage.
interface hdb3_vb_insert_if;
    import hdb3_pkg::*;

    logic  en;
    logic  data_in;
    code_t code_out;
    logic  out_valid;

    modport master (output en, output data_in, input code_out, input out_valid);
    modport slave  (input en, input data_in, output code_out, output out_valid);

endinterface

// File: rtl/hdb3_vb_insert.sv
// hdb3_vb_insert
// HDB3 substitution stage. Takes one NRZ bit per enabled clock and emits a
// 2-bit symbol code per enabled clock, replacing each run of HDB_N+1 zeros
// with 000V (odd pulse parity since last V) or B00V (even parity).
// A delay line of HDB_N+1 codes lets the B be written retroactively over
// the first zero of the run, which reaches the last stage on the same edge
// that the V enters the first stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low, priority over en
//   bus   : slave side of hdb3_vb_insert_if (en, data_in, code_out, out_valid)
module hdb3_vb_insert
    import hdb3_pkg::*;
#(
    parameter int HDB_N = 3     // legal 2..7; substituted run is HDB_N+1
) (
    input  logic clk,
    input  logic rst_n,
    hdb3_vb_insert_if.slave bus
);

    code_t      sr [0:HDB_N];   // delay line, code_out taps the last stage
    logic [2:0] zcnt;           // zeros since last mark or V
    logic       par;            // parity of marks + Bs since last V
    logic [3:0] pcnt;           // enabled edges since reset, saturating
    logic       out_valid_q;

    localparam logic [2:0] ZMAX = 3'(HDB_N);
    localparam logic [3:0] PSAT = 4'(HDB_N + 1);
    localparam logic [3:0] PRDY = 4'(HDB_N);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= HDB_N; i++) sr[i] <= CODE_ZERO;
            zcnt        <= '0;
            par         <= 1'b0;
            pcnt        <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.en) begin
            for (int i = 1; i <= HDB_N; i++) sr[i] <= sr[i-1];

            if (pcnt != PSAT) pcnt <= pcnt + 4'd1;
            // pcnt is the count before this edge, so >= HDB_N means this is
            // sample HDB_N+1 or later and the last stage now holds real data.
            out_valid_q <= (pcnt >= PRDY);

            if (bus.data_in) begin
                sr[0] <= CODE_MARK;
                zcnt  <= '0;
                par   <= ~par;
            end else if (zcnt == ZMAX) begin
                sr[0] <= CODE_V;
                zcnt  <= '0;
                par   <= 1'b0;
                // Even parity: overwrite the first zero of the run (moving
                // into the last stage this edge) with a balancing pulse.
                // This later assignment wins over the shift above.
                if (!par) sr[HDB_N] <= CODE_B;
            end else begin
                sr[0] <= CODE_ZERO;
                zcnt  <= zcnt + 3'd1;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.code_out  = sr[HDB_N];
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// tb_hdb3_vb_insert
// Self-checking bench for hdb3_vb_insert (HDB_N=3). A behavioural model
// builds the full output symbol list from the input bits (B patched back
// over the first zero of each substituted run) and the expected code_out
// after enabled edge k is element k-1-HDB_N of that list. Directed
// scenarios additionally compare the captured valid symbols to constants.
module tb_hdb3_vb_insert;
    import hdb3_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdb3_vb_insert_if bus ();

    hdb3_vb_insert #(.HDB_N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    code_t mq [$];      // full symbol list since reset
    code_t vq [$];      // observed codes on valid cycles since reset
    int    zrun, pulses, k;
    code_t last_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic code_t sym(input byte c);
        case (c)
            "1":     return CODE_MARK;
            "B":     return CODE_B;
            "V":     return CODE_V;
            default: return CODE_ZERO;
        endcase
    endfunction

    // Append one input bit to the reference symbol list.
    task automatic model_push(input logic d);
        if (d) begin
            mq.push_back(CODE_MARK);
            pulses++;
            zrun = 0;
        end else begin
            zrun++;
            if (zrun == N + 1) begin
                mq.push_back(CODE_V);
                if (pulses % 2 == 0) mq[mq.size() - 1 - N] = CODE_B;
                pulses = 0;
                zrun   = 0;
            end else begin
                mq.push_back(CODE_ZERO);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.data_in = 1'b0;
        @(posedge clk); #1;
        chk("rst_code", 32'(bus.code_out), 32'(CODE_ZERO));
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        mq.delete(); vq.delete();
        zrun = 0; pulses = 0; k = 0; last_code = CODE_ZERO;
    endtask

    task automatic step(input logic e, input logic d);
        code_t exp_code;
        logic  exp_vld;
        bus.en = e;
        bus.data_in = d;
        @(posedge clk); #1;
        if (e) begin
            model_push(d);
            k++;
            exp_code  = (k > N) ? mq[k - 1 - N] : CODE_ZERO;
            last_code = exp_code;
            exp_vld   = (k > N);
        end else begin
            exp_code = last_code;
            exp_vld  = 1'b0;
        end
        chk("code", 32'(bus.code_out), 32'(exp_code));
        chk("valid", 32'(bus.out_valid), 32'(exp_vld));
        if (bus.out_valid) vq.push_back(bus.code_out);
    endtask

    // '0'/'1' enabled bits, 's' one stalled cycle.
    task automatic run(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "s") step(1'b0, 1'($urandom_range(0, 1)));
            else             step(1'b1, s[i] == "1");
        end
    endtask

    task automatic expect_codes(input string tag, input string c);
        chk({tag, "_count"}, 32'(vq.size() >= c.len()), 32'd1);
        for (int i = 0; i < c.len() && i < vq.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(vq[i]), 32'(sym(c[i])));
    endtask

    initial begin
        bus.en = 1'b0;
        bus.data_in = 1'b0;

        do_reset(); run("0000111");         expect_codes("b00v", "B00V");
        do_reset(); run("10000111");        expect_codes("m000v", "1000V");
        do_reset(); run("110000111");       expect_codes("mmb00v", "11B00V");
        do_reset(); run("00000000100001111");
        expect_codes("eight0", "B00VB00V1000V");
        do_reset(); run("0001111");         expect_codes("no_v", "0001");
        do_reset(); run("00sss00111");      expect_codes("stall", "B00V");
        do_reset(); run("1000");
        do_reset(); run("0000111");         expect_codes("midrst", "B00V");

        // randomized: zero-biased data, random stalls, occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else step($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
